// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid-buffer state encoding and occupancy width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_skid_reg.sv
// Registered valid/ready pipeline stage. Define PIPE_SKID_EN for a two-entry skid
// buffer with a registered in_ready; otherwise a single entry with pass-through ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occ
);

  logic             accept_s;
  logic             retire_s;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [OCC_W-1:0] occ_q,       occ_d;

  assign accept_s  = in_valid & in_ready;
  assign retire_s  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign occ       = occ_q;

`ifdef PIPE_SKID_EN
  state_e           state_q,    state_d;
  logic [WIDTH-1:0] skid_q,     skid_d;
  logic             in_ready_q, in_ready_d;

  // Ready comes from a flop; only rst/flush gate it, never out_ready.
  assign in_ready = in_ready_q & ~rst & ~flush;

  // Next-state, entry movement and registered status for the two-entry buffer.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    skid_d     = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          state_d    = BUSY;
          out_data_d = in_data;
        end else begin
          state_d = EMPTY;
        end
      end
      BUSY: begin
        if (accept_s && !retire_s) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (retire_s && !accept_s) begin
          state_d = EMPTY;
        end else if (accept_s && retire_s) begin
          out_data_d = in_data;
        end else begin
          state_d = BUSY;
        end
      end
      FULL: begin
        if (retire_s) begin
          state_d    = BUSY;
          out_data_d = skid_q;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A flush empties the stage but leaves the visible payload untouched.
    if (flush) begin
      state_d    = EMPTY;
      out_data_d = out_data_q;
      skid_d     = skid_q;
    end else begin
      state_d = state_d;
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
    case (state_d)
      EMPTY:   occ_d = 2'd0;
      BUSY:    occ_d = 2'd1;
      FULL:    occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // Skid-specific state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      skid_q     <= {WIDTH{1'b0}};
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  assign in_ready = ~rst & ~flush & (~out_valid_q | out_ready);

  // Single entry: load on accept, drop on retire, flush clears valid only.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end else if (retire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    occ_d = {1'b0, out_valid_d};
  end
`endif

  // Output-facing registers shared by both configurations.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= RST_VAL;
      occ_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      occ_q       <= occ_d;
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter RST_VAL, default 0, WIDTH-bit value loaded into out_data on reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all held entries (branch redirect).
REQ-006 SHALL have port in_valid  input  1  upstream presents a payload.
REQ-007 SHALL have port in_ready  output  1  stage can accept a payload this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid payload.
REQ-010 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  registered payload to downstream.
REQ-012 SHALL have port occ  output  2  entries held (0, 1, or 2 with skid).

Function
REQ-013 SHALL accept a payload only on a cycle with in_valid && in_ready (accept), and SHALL retire one only on out_valid && out_ready (retire).
REQ-014 SHALL drive out_data and out_valid directly from flops; latency from accept to out_valid is 1 cycle when empty.
REQ-015 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-016 SHALL preserve FIFO order; no payload lost or duplicated absent flush.
REQ-017 SHALL on simultaneous accept and retire with occ=1 replace the output entry with in_data, keeping occ=1 (full throughput, one payload/cycle).
REQ-018 SHALL on flush=1 set occ=0 and out_valid=0 at the next edge, discard any same-cycle accept, leave out_data unchanged; flush overrides accept and retire.
REQ-019 SHALL drive in_ready=0 during a flush cycle.
REQ-020 SHALL treat in_data as don't-care when in_valid=0; out_data only loads on accept.

Reset
REQ-021 SHALL on rst=1 set out_valid=0, occ=0, out_data=RST_VAL, skid entry cleared, state EMPTY; rst overrides flush and all handshakes.
REQ-022 SHALL drive in_ready=0 while rst=1 and in_ready per REQ-024/REQ-026 from the first cycle after rst deasserts.
REQ-023 SHALL discard any in-flight payload when rst asserts mid-transfer.

Configuration
REQ-024 Without macro PIPE_SKID_EN: single entry; in_ready = !out_valid || out_ready (combinational from out_ready); occ in {0,1}; occ[1] tied 0.
REQ-025 With PIPE_SKID_EN defined: two entries (main + skid); in_ready is a flop output with no combinational path from out_ready.
REQ-026 With PIPE_SKID_EN, state machine EMPTY/BUSY/FULL; in_ready=1 in EMPTY and BUSY, 0 in FULL.
REQ-027 EMPTY: accept -> BUSY (main<=in_data).
REQ-028 BUSY: accept&&!retire -> FULL (skid<=in_data); retire&&!accept -> EMPTY; both -> BUSY (main<=in_data); neither -> BUSY.
REQ-029 FULL: retire -> BUSY (main<=skid); else FULL.
REQ-030 With PIPE_SKID_EN, flush from any state -> EMPTY; occ equals 0/1/2 for EMPTY/BUSY/FULL.

Structure
REQ-031 SHALL place the state typedef (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and the occupancy width constant in shared package pipe_pkg.
REQ-032 SHALL be a single module with no sub-module; the stage buffers in the core are replaced by instances of it with payload concatenated into in_data.

Verification
REQ-033 Reset: rst=1 two cycles with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, out_data=RST_VAL, occ=0, in_ready=0.
REQ-034 Streaming: out_ready=1, payloads 1..8 on consecutive cycles -> out_data 1..8 on consecutive cycles, 1-cycle latency, no bubbles.
REQ-035 Backpressure: out_ready=0 with A=32'h11 then B=32'h22 offered -> with PIPE_SKID_EN occ=2, in_ready=0, then out_ready=1 yields A then B; without it in_ready=0 after A and B is held upstream.
REQ-036 Flush: occ=2 holding 32'h33,32'h44, flush=1 with in_valid=1 in_data=32'h55 -> next cycle out_valid=0, occ=0; 32'h55 never appears.
REQ-037 Random: 10k cycles random in_valid/out_ready/flush, both configurations -> scoreboard order match, out_data stable under stall, occ consistent with accept/retire count.
